seq_u_bam_mul: RTL and testbench
================================

SEQ_U_BAM_MUL -- requirements
Module: seq_u_bam_mul

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter: HW, default $clog2(N)+1, width of the h_cut port.
REQ-003 Parameter: VW, default $clog2(2*N)+1, width of the v_cut port.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a  input  N  unsigned multiplicand.
REQ-007 b  input  N  unsigned multiplier.
REQ-008 h_cut  input  HW  horizontal break; rows j < h_cut are dropped.
REQ-009 v_cut  input  VW  vertical break; columns i+j < v_cut are dropped.
REQ-010 in_valid  input  1  operand/cut set present.
REQ-011 in_ready  output  1  block can accept operands.
REQ-012 seq_u_bam_mul_out  output  2N  approximate product.
REQ-013 out_valid  output  1  seq_u_bam_mul_out holds a finished result.
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 The result SHALL be the exact 2N-bit sum of kept partial products a[i]&b[j]·2^(i+j), where a term is kept iff j >= h_cut and i+j >= v_cut; no bits are truncated, and bit 2N-1 is a true carry.
REQ-016 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-017 in_ready SHALL equal 1 exactly when the state is IDLE; in_valid SHALL be ignored in any other state.
REQ-018 In IDLE with in_valid=1 on a clock edge:
  - a, b, h_cut and v_cut SHALL be captured into internal registers.
  - The accumulator SHALL be cleared.
  - The row index SHALL be loaded with min(h_cut, N).
  - The state SHALL move to CALC.
REQ-019 On each CALC cycle:
  - If the row index is < N, the masked row (a & keep-mask) << j SHALL be added into the 2N-bit accumulator.
  - The row index SHALL then be incremented.
REQ-020 CALC SHALL last exactly max(N - min(h_cut,N), 1) cycles, after which the state moves to DONE; h_cut >= N SHALL give one CALC cycle and a zero result.
REQ-021 v_cut >= 2N-1 SHALL yield a zero result; captured operands SHALL NOT change while in CALC or DONE, whatever the inputs do.
REQ-022 In DONE:
  - out_valid SHALL be 1.
  - seq_u_bam_mul_out SHALL hold the accumulator and stay stable until out_ready=1 is sampled.
  - The state SHALL then return to IDLE.
REQ-023 out_valid SHALL be 0 in IDLE and CALC.
REQ-024 seq_u_bam_mul_out SHALL keep the last result after DONE→IDLE until the next result is loaded.
REQ-025 The state SHALL NOT go from DONE directly to CALC; minimum issue interval is CALC length + 2 cycles.
REQ-026 Latency:
  - Out_valid SHALL rise max(N-min(h_cut,N),1) + 1 edges after the accepting edge.
  - N=8, h_cut=0 gives 9 edges.

Reset
REQ-027 With rst=1 at an edge:
  - The state SHALL become IDLE.
  - The accumulator, seq_u_bam_mul_out and the captured registers SHALL become 0.
  - out_valid SHALL become 0.
  - in_ready SHALL then read 1.
REQ-028 rst SHALL take priority over every other input, including in_valid and out_ready on the same edge.
REQ-029 Reset mid-CALC or mid-DONE SHALL abort the operation; no result is emitted for it.
REQ-030 The next accepted operation after reset SHALL be computed correctly.

Verification
REQ-031 N=8, h_cut=0, v_cut=0, a=255, b=255, out_ready=1 -> out 65025, out_valid 9 edges after accept, for exactly 1 cycle.
REQ-032 N=8, h_cut=2, v_cut=9, a=255, b=255 -> out 61440 (0xF000, bit 15 set), CALC 6 cycles.
REQ-033 N=8, h_cut=8, v_cut=0, a=200, b=255 -> out 0 after 1 CALC cycle; h_cut=0, v_cut=15, a=b=255 -> out 0.
REQ-034 Backpressure: result 13·11=143 (h=0, v=0) with out_ready=0 for 5 cycles:
  - out_valid and out SHALL stay stable.
  - in_ready SHALL stay 0.
  - in_valid pulses SHALL be ignored.
  - Release SHALL give one handshake, then IDLE.
REQ-035 Reset mid-operation: rst pulse on the 3rd CALC cycle:
  - The next edge SHALL show out_valid=0, out=0, in_ready=1.
  - A following a=7, b=9, h=0, v=0 SHALL return 63.
REQ-036 Randomized N=8 and N=16 operands and cuts SHALL match a software BAM model per REQ-015, with the handshake held/released at random.

Source files
------------

// File: rtl/seq_u_bam_mul.sv
// Sequential unsigned broken-array multiplier: one partial-product row per cycle,
// rows below h_cut and columns below v_cut are dropped from the exact 2N-bit sum.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | adding one masked row per cycle
// DONE  | result held on the output until out_ready
module seq_u_bam_mul #(
  parameter int N  = 8,
  parameter int HW = $clog2(N) + 1,
  parameter int VW = $clog2(2 * N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [HW-1:0]   h_cut,
  input  logic [VW-1:0]   v_cut,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2*N-1:0]  seq_u_bam_mul_out,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int RW = $clog2(N + 1) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [HW-1:0]   h_r;
  logic [VW-1:0]   v_r;
  logic [RW-1:0]   row;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  out_r;
  logic            out_valid_r;
  logic            in_ready_r;

  logic [N-1:0]    keep_mask;
  logic [N-1:0]    b_shift;
  logic            row_active;
  logic            last_row;
  logic [2*N-1:0]  row_sum;
  logic [2*N-1:0]  acc_next;
  logic [RW-1:0]   row_start;

  assign in_ready          = in_ready_r;
  assign out_valid         = out_valid_r;
  assign seq_u_bam_mul_out = out_r;

  // Rows at or beyond N contribute nothing; they only occur when h_cut >= N.
  assign b_shift    = b_r >> row;
  assign row_active = (int'(row) < N) && (int'(row) >= int'(h_r)) && b_shift[0];
  assign last_row   = int'(row) >= (N - 1);
  assign row_start  = (int'(h_cut) >= N) ? RW'(N) : RW'(h_cut);

  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < N; i++) begin
      keep_mask[i] = (i + int'(row)) >= int'(v_r);
    end
    row_sum = '0;
    if (row_active) begin
      row_sum = {{N{1'b0}}, a_r & keep_mask} << row;
    end
    acc_next = acc + row_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      h_r         <= '0;
      v_r         <= '0;
      row         <= '0;
      acc         <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            h_r        <= h_cut;
            v_r        <= v_cut;
            acc        <= '0;
            row        <= row_start;
            in_ready_r <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          row <= row + RW'(1);
          if (last_row) begin
            out_r       <= acc_next;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_u_bam_mul.sv
// Bench for seq_u_bam_mul: table vectors, handshake/reset corner sequences and
// randomized N=8 / N=16 traffic checked through result scoreboards.
module tb_seq_u_bam_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst;
  logic [7:0]  a, b;
  logic [3:0]  h;
  logic [4:0]  v;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] y;

  logic        rst16;
  logic [15:0] a16, b16;
  logic [4:0]  h16;
  logic [5:0]  v16;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [31:0] y16;

  seq_u_bam_mul #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .h_cut(h), .v_cut(v),
    .in_valid(in_valid), .in_ready(in_ready), .seq_u_bam_mul_out(y),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  seq_u_bam_mul #(.N(16)) dut16 (
    .clk(clk), .rst(rst16), .a(a16), .b(b16), .h_cut(h16), .v_cut(v16),
    .in_valid(in_valid16), .in_ready(in_ready16), .seq_u_bam_mul_out(y16),
    .out_valid(out_valid16), .out_ready(out_ready16)
  );

  function automatic longint bam(longint aa, longint bb, longint hh, longint vv, int n);
    longint s = 0;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < n; i++)
        if (((aa >> i) & 1) == 1 && ((bb >> j) & 1) == 1 && j >= hh && (i + j) >= vv)
          s += longint'(1) << (i + j);
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboards: push on an accepting edge, pop on a handshaking edge.
  longint q8[$];
  longint q16[$];
  logic   use_tab = 1'b0;
  longint tab_exp = 0;

  always @(negedge clk) begin
    if (rst) q8.delete();
    else begin
      if (in_valid && in_ready) q8.push_back(use_tab ? tab_exp : bam(a, b, h, v, 8));
      if (out_valid && out_ready) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb8_spurious: got result %0d expected none", y);
        end else check("sb8_result", y, q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst16) q16.delete();
    else begin
      if (in_valid16 && in_ready16) q16.push_back(bam(a16, b16, h16, v16, 16));
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb16_spurious: got result %0d expected none", y16);
        end else check("sb16_result", y16, q16.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [3:0] ih, input logic [4:0] iv, input longint exp);
    int t = 0;
    while (!in_ready && t < 200) begin tick(); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue8_timeout: in_ready got 0 expected 1");
    end
    a = ia; b = ib; h = ih; v = iv; tab_exp = exp; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain8();
    int t = 0;
    while (q8.size() != 0 && t < 300) begin tick(); t++; end
    check("drain8_pending", q8.size(), 0);
  endtask

  // Edges counted with the accepting edge as the first one.
  task automatic latency8(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [3:0] ih, input logic [4:0] iv,
                          input longint exp, output int n);
    issue8(ia, ib, ih, iv, exp);
    n = 1;
    check("in_ready_in_calc", in_ready, 0);
    while (!out_valid && n < 50) begin tick(); n++; end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] h;
    logic [4:0] v;
    longint     exp;
  } vec_t;

  vec_t vt[14];
  logic stop_bp;

  initial begin
    int n;
    vt[0]  = '{8'd255, 8'd255, 4'd0, 5'd0,  65025};
    vt[1]  = '{8'd255, 8'd255, 4'd2, 5'd9,  61440};
    vt[2]  = '{8'd200, 8'd255, 4'd8, 5'd0,  0};
    vt[3]  = '{8'd255, 8'd255, 4'd0, 5'd15, 0};
    vt[4]  = '{8'd13,  8'd11,  4'd0, 5'd0,  143};
    vt[5]  = '{8'd7,   8'd9,   4'd0, 5'd0,  63};
    vt[6]  = '{8'd1,   8'd1,   4'd0, 5'd0,  1};
    vt[7]  = '{8'd1,   8'd1,   4'd0, 5'd1,  0};
    vt[8]  = '{8'd128, 8'd128, 4'd0, 5'd0,  16384};
    vt[9]  = '{8'd255, 8'd1,   4'd1, 5'd0,  0};
    vt[10] = '{8'd3,   8'd3,   4'd0, 5'd1,  8};
    vt[11] = '{8'd255, 8'd255, 4'd7, 5'd0,  32640};
    vt[12] = '{8'd255, 8'd255, 4'd0, 5'd14, 16384};
    vt[13] = '{8'd255, 8'd255, 4'd0, 5'd13, 32768};

    rst = 1'b1; a = '0; b = '0; h = '0; v = '0; in_valid = 1'b0; out_ready = 1'b1;
    rst16 = 1'b1; a16 = '0; b16 = '0; h16 = '0; v16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b1;
    stop_bp = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", y, 0);

    // Reset wins over in_valid on the same edge.
    in_valid = 1'b1; a = 8'd5; b = 8'd5;
    tick();
    check("rst_prio_in_ready", in_ready, 1);
    in_valid = 1'b0; rst = 1'b0; rst16 = 1'b0;
    tick();

    use_tab = 1'b1;
    foreach (vt[k]) begin
      issue8(vt[k].a, vt[k].b, vt[k].h, vt[k].v, vt[k].exp);
      drain8();
    end

    latency8(8'd255, 8'd255, 4'd0, 5'd0, 65025, n);
    check("latency_h0", n, 9);
    check("out_h0", y, 65025);
    tick();
    check("valid_one_cycle", out_valid, 0);
    check("idle_after_done", in_ready, 1);
    latency8(8'd255, 8'd255, 4'd2, 5'd9, 61440, n);
    check("latency_h2", n, 7);
    tick();
    latency8(8'd200, 8'd255, 4'd8, 5'd0, 0, n);
    check("latency_h8", n, 2);
    tick();

    // Backpressure: result held, new operands ignored.
    out_ready = 1'b0;
    latency8(8'd13, 8'd11, 4'd0, 5'd0, 143, n);
    for (int c = 0; c < 5; c++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      in_valid = c[0];
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out", y, 143);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_out_kept", y, 143);
    drain8();

    // Reset on the third CALC cycle aborts the operation.
    issue8(8'd255, 8'd255, 4'd0, 5'd0, 65025);
    tick(); tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_out", y, 0);
    check("abort_in_ready", in_ready, 1);
    issue8(8'd7, 8'd9, 4'd0, 5'd0, 63);
    drain8();
    check("after_abort_out", y, 63);

    // Randomized traffic on both widths with random backpressure.
    use_tab = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++)
          issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 9)), 5'($urandom_range(0, 17)), 0);
      end
      begin
        for (int k = 0; k < 25; k++) begin
          int t = 0;
          while (!in_ready16 && t < 400) begin tick(); t++; end
          if (!in_ready16) begin
            checks++; errors++;
            $display("FAIL issue16_timeout: in_ready got 0 expected 1");
          end
          a16 = 16'($urandom); b16 = 16'($urandom);
          h16 = 5'($urandom_range(0, 17)); v16 = 6'($urandom_range(0, 33));
          in_valid16 = 1'b1;
          tick();
          in_valid16 = 1'b0;
        end
      end
      begin
        while (!stop_bp) begin
          out_ready = 1'($urandom_range(0, 1));
          out_ready16 = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join_any
    stop_bp = 1'b1;
    out_ready = 1'b1; out_ready16 = 1'b1;
    drain8();
    begin
      int t = 0;
      while (q16.size() != 0 && t < 300) begin tick(); t++; end
      check("drain16_pending", q16.size(), 0);
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
